// File: rtl/data_rx_pkg.sv
// Shared definitions for the data_rx load/store block: RV32I funct3 codes,
// FSM state type and the funct3 legality check.
package data_rx_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Stores only know the signed codes; loads also accept the unsigned variants.
  function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
    if (write)
      return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
           (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/data_rx_mem.sv
// Word-organised storage for data_rx: one synchronous port, byte-lane write
// enables and a registered read. Contents are deliberately never reset.
module data_rx_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read returns the word as it was before a same-cycle write.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i])
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_rx.sv
// Load/store slave with programmable wait states and RV32I sub-word access.
// Define DATA_RX_ALIGN_CHK_EN to flag misaligned half/word accesses as errors.
module data_rx
  import data_rx_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t           state, next_state;
  logic [3:0]       wait_cnt;
  logic             accept;
  logic             cap_write;
  logic [2:0]       cap_f3;
  logic [AW+1:0]    cap_addr;
  logic [WIDTH-1:0] cap_wdata;
  logic [1:0]       size;
  logic [1:0]       lane;
  logic             acc_err;
  logic [AW-1:0]    mem_addr;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [WIDTH-1:0] load_val;
  logic             unused_addr_bits;

  assign req_ready        = (state == IDLE);
  assign resp_valid       = (state == RESP);
  assign accept           = req_valid && req_ready;
  assign unused_addr_bits = ^req_addr[WIDTH-1:AW+2];

  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (req_valid) next_state = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
      WAIT:    if (wait_cnt == 4'd0) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    if (resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt  <= 4'd0;
      cap_write <= 1'b0;
      cap_f3    <= 3'b000;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      wait_cnt  <= WAIT_LOAD;
      cap_write <= req_write;
      cap_f3    <= req_funct3;
      cap_addr  <= req_addr[AW+1:0];
      cap_wdata <= req_wdata;
    end else if (state == WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Legality and byte-lane selection for the captured request.
  always_comb begin
    size = cap_f3[1:0];
    lane = cap_addr[1:0];
`ifdef DATA_RX_ALIGN_CHK_EN
    acc_err = !f3_legal(cap_write, cap_f3) ||
              (size == 2'b01 && lane[0]) || (size == 2'b10 && lane != 2'b00);
`else
    acc_err = !f3_legal(cap_write, cap_f3);
    if (size == 2'b01)
      lane[0] = 1'b0;
    else if (size == 2'b10)
      lane = 2'b00;
`endif
  end

  always_comb begin
    mem_be    = 4'b0000;
    mem_wdata = cap_wdata;
    case (size)
      2'b00: begin
        mem_be    = 4'b0001 << lane;
        mem_wdata = {(WIDTH/8){cap_wdata[7:0]}};
      end
      2'b01: begin
        mem_be    = lane[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {(WIDTH/16){cap_wdata[15:0]}};
      end
      2'b10:   mem_be = 4'b1111;
      default: mem_be = 4'b0000;
    endcase

    sel_byte = mem_rdata[{lane, 3'b000} +: 8];
    sel_half = mem_rdata[{lane[1], 4'b0000} +: 16];
    case (cap_f3)
      F3_B:    load_val = {{(WIDTH-8){sel_byte[7]}}, sel_byte};
      F3_H:    load_val = {{(WIDTH-16){sel_half[15]}}, sel_half};
      F3_W:    load_val = mem_rdata;
      F3_BU:   load_val = {{(WIDTH-8){1'b0}}, sel_byte};
      F3_HU:   load_val = {{(WIDTH-16){1'b0}}, sel_half};
      default: load_val = '0;
    endcase
  end

  // The read is launched at the accept edge so ACCESS already sees the word;
  // a reset asserted during ACCESS must also suppress the write.
  assign mem_addr = (state == IDLE) ? req_addr[AW+1:2] : cap_addr[AW+1:2];
  assign mem_we   = (state == ACCESS) && cap_write && !acc_err && rst;

  data_rx_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .be   (mem_be),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      resp_err   <= acc_err;
      resp_rdata <= (acc_err || cap_write) ? '0 : load_val;
    end
  end

endmodule

// File: tb/tb_data_rx.sv
// Self-checking bench for data_rx: directed vectors, reset aborts and random
// traffic against a byte-addressed reference model.
module tb_data_rx;

  localparam int WIDTH       = 32;
  localparam int DEPTH       = 256;
  localparam int WAIT_CYCLES = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [0:4*DEPTH-1];

  always #5 clk = ~clk;

  data_rx #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  // Reference: memory as a flat byte array, accesses as little-endian byte runs.
  function automatic void ref_access(input logic wr, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wdata,
                                     output logic [31:0] rdata, output logic err);
    int a;
    int nbytes;
    logic legal;
    logic [31:0] v;
    a      = int'(addr % (4*DEPTH));
    legal  = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = 1 << f3[1:0];
    err    = !legal;
    rdata  = 32'h0;
`ifdef DATA_RX_ALIGN_CHK_EN
    if (legal && (a % nbytes) != 0) err = 1'b1;
`else
    a = a - (a % nbytes);
`endif
    if (err) return;
    if (wr) begin
      for (int i = 0; i < nbytes; i++) ref_mem[a+i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
      if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | (32'hFFFF_FFFF << (8*nbytes));
      rdata = v;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One full request/response handshake with its checks.
  task automatic applyStimulus(input string tag, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input int hold, input bit early,
                               input logic [31:0] exp_rdata, input logic exp_err);
    int j;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = early;
    j = 0;
    while (!req_ready && j < 50) begin
      @(negedge clk);
      j++;
    end
    if (!req_ready) begin
      checkOutput({tag, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    j = 0;
    while (!resp_valid && j < 50) begin
      @(negedge clk);
      j++;
    end
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
    if (!resp_valid) begin
      resp_ready = 1'b0;
      return;
    end
    checkOutput({tag, "_latency"}, 32'(j + 1), 32'(WAIT_CYCLES + 2));
    checkOutput({tag, "_rdata"}, resp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    if (!early) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        checkOutput({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
        checkOutput({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput({tag, "_valid_drop"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_ready_back"}, 32'(req_ready), 32'd1);
    resp_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                          input bit early, input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] r;
    logic        e;
    ref_access(wr, f3, addr, wdata, r, e);
    applyStimulus(tag, wr, f3, addr, wdata, hold, early, exp_rdata, exp_err);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] exp_r;
    logic        exp_e;
    logic [31:0] d;
    logic [31:0] a;
    logic [2:0]  f3;
    logic        wr;
    bit          seen;

    repeat (3) @(negedge clk);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);

    directed("sw_10", 1, 3'b010, 32'h10, 32'hDEADBEEF, 1, 0, 32'h0, 0);
    directed("lw_10", 0, 3'b010, 32'h10, 32'h0, 2, 0, 32'hDEADBEEF, 0);
    directed("lb_13", 0, 3'b000, 32'h13, 32'h0, 0, 0, 32'hFFFFFFDE, 0);
    directed("lbu_13", 0, 3'b100, 32'h13, 32'h0, 0, 0, 32'h000000DE, 0);
    directed("lh_10", 0, 3'b001, 32'h10, 32'h0, 0, 0, 32'hFFFFBEEF, 0);
    directed("lhu_12", 0, 3'b101, 32'h12, 32'h0, 0, 0, 32'h0000DEAD, 0);
    directed("sb_11", 1, 3'b000, 32'h11, 32'h00000055, 0, 0, 32'h0, 0);
    directed("lw_after_sb", 0, 3'b010, 32'h10, 32'h0, 0, 0, 32'hDEAD55EF, 0);
`ifdef DATA_RX_ALIGN_CHK_EN
    directed("lw_12_misal", 0, 3'b010, 32'h12, 32'h0, 0, 0, 32'h0, 1);
`else
    directed("lw_12_misal", 0, 3'b010, 32'h12, 32'h0, 0, 0, 32'hDEAD55EF, 0);
`endif
    directed("ld_f3_011", 0, 3'b011, 32'h10, 32'h0, 0, 0, 32'h0, 1);
    directed("st_f3_100", 1, 3'b100, 32'h10, 32'h11223344, 0, 0, 32'h0, 1);
    directed("lw_after_bad_st", 0, 3'b010, 32'h10, 32'h0, 0, 0, 32'hDEAD55EF, 0);
    directed("lw_wrap", 0, 3'b010, 32'h410, 32'h0, 0, 0, 32'hDEAD55EF, 0);
    directed("lw_early_ready", 0, 3'b010, 32'h10, 32'h0, 0, 1, 32'hDEAD55EF, 0);
    directed("sw_20", 1, 3'b010, 32'h20, 32'hCAFEF00D, 0, 0, 32'h0, 0);

    // Store aborted by reset while in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_wait_busy", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("abort_wait_idle", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    checkOutput("abort_wait_noresp", 32'(seen), 32'd0);

    // Store aborted by reset while in ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h87654321;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    checkOutput("abort_access_noresp", 32'(seen), 32'd0);

    directed("lw_20_after_abort", 0, 3'b010, 32'h20, 32'h0, 5, 0, 32'hCAFEF00D, 0);

    $display("[TB] random phase");
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      directed("init", 1, 3'b010, 32'(w*4), d, 0, 0, 32'h0, 0);
    end
    for (int t = 0; t < 120; t++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom << 10) | 32'($urandom_range(0, 63));
      d  = $urandom;
      ref_access(wr, f3, a, d, exp_r, exp_e);
      applyStimulus("rand", wr, f3, a, d, $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), exp_r, exp_e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_rx.md
DATA_RX -- requirements
Module: data_rx

Interface
REQ-001 Parameter WIDTH, default 32, data and address width.
REQ-002 Parameter DEPTH, default 256, number of WIDTH-bit words in storage; power of two.
REQ-003 Parameter WAIT_CYCLES, default 1, wait states inserted before each access; range 0..15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 req_valid  in  1  initiator presents a load/store request.
REQ-007 req_ready  out  1  block accepts a request this cycle.
REQ-008 req_write  in  1  1 = store, 0 = load.
REQ-009 req_funct3  in  3  access size/sign code (RV32I load/store Funct3).
REQ-010 req_addr  in  WIDTH  byte address.
REQ-011 req_wdata  in  WIDTH  store data, right-aligned.
REQ-012 resp_valid  out  1  response available.
REQ-013 resp_ready  in  1  initiator consumes response.
REQ-014 resp_rdata  out  WIDTH  load result, extended per funct3; 0 for stores and errors.
REQ-015 resp_err  out  1  request illegal; no storage side effect.

Function
REQ-016 FSM states SHALL be IDLE, WAIT, ACCESS, RESP; req_ready SHALL be 1 only in IDLE, decoded from state.
REQ-017 IDLE: on req_valid && req_ready, capture req_write/funct3/addr/wdata; go WAIT if WAIT_CYCLES>0, else ACCESS.
REQ-018 WAIT: down-counter loaded with WAIT_CYCLES-1 on accept; go ACCESS when it reaches 0.
REQ-019 ACCESS: single cycle performing the storage read or byte-enabled write, registering resp_rdata/resp_err; go RESP.
REQ-020 RESP: resp_valid=1, resp_rdata and resp_err held stable until resp_ready; on resp_ready go IDLE and drop resp_valid next cycle.
REQ-021 Latency: request accepted at edge N -> resp_valid high from cycle N+WAIT_CYCLES+2.
REQ-022 Word index = req_addr[log2(DEPTH)+1:2]; upper address bits ignored (address wraps modulo 4*DEPTH).
REQ-023 Loads: 000 LB sign-extend byte addr[1:0]; 001 LH sign-extend half addr[1]; 010 LW; 100 LBU, 101 LHU zero-extend.
REQ-024 Stores: 000 SB, 001 SH, 010 SW write only addressed bytes from req_wdata low bits; other bytes unchanged.
REQ-025 Illegal funct3 (load 011/110/111; store any other than 000/001/010): resp_err=1, resp_rdata=0, no write.
REQ-026 req_valid while not IDLE SHALL be ignored; initiator holds it until req_ready.
REQ-027 resp_ready already high when RESP entered: one-cycle RESP; next request acceptable the following cycle (IDLE).

Reset
REQ-028 rst low at an edge: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0; req_ready 1 once rst high.
REQ-029 Reset mid-operation aborts the request; a store reset during WAIT or ACCESS SHALL NOT modify storage; no response issued.
REQ-030 Storage contents SHALL NOT be reset.

Configuration
REQ-031 Macro DATA_RX_ALIGN_CHK_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 -> resp_err=1, resp_rdata=0, no write.
REQ-032 Macro undefined: misaligned addresses silently aligned (addr[0] cleared for half, addr[1:0] for word); resp_err only per REQ-025.

Structure
REQ-033 Package data_rx_pkg SHALL hold funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state typedef.
REQ-034 Storage array SHALL be sub-module data_rx_mem: one synchronous port, 4-bit byte enable, registered read.

Verification
REQ-035 Reset, SW 0xDEADBEEF @0x10, LW @0x10, WAIT_CYCLES=1 -> resp_rdata 0xDEADBEEF, resp_valid at accept+3.
REQ-036 After REQ-035: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x10 -> 0xFFFFBEEF; LHU @0x12 -> 0x0000DEAD.
REQ-037 SB 0x55 @0x11 then LW @0x10 -> 0xDEAD55EF.
REQ-038 LW @0x12: with DATA_RX_ALIGN_CHK_EN -> resp_err 1, rdata 0; without -> rdata 0xDEAD55EF, err 0.
REQ-039 Load funct3 011 -> resp_err 1; store funct3 100 -> resp_err 1, following LW shows storage unchanged.
REQ-040 SW 0x12345678 @0x20, rst low during WAIT -> no response; LW @0x20 returns prior content; resp_ready held low 5 cycles keeps resp_rdata stable.
